// File: rtl/stream_pkg.sv
// Shared stream beat definitions used by the packet FIFO and the arbiter glue code.
// A beat is packed as {last, qos, data} with last in the MSB.
package stream_pkg;

  localparam int STREAM_DATA_W = 8;
  localparam int STREAM_QOS_W  = 4;
  localparam int STREAM_BEAT_W = STREAM_DATA_W + STREAM_QOS_W + 1;

  typedef struct packed {
    logic                     last;
    logic [STREAM_QOS_W-1:0]  qos;
    logic [STREAM_DATA_W-1:0] data;
  } stream_beat_t;

  function automatic logic [STREAM_BEAT_W-1:0] pack_beat(
    input logic                     last,
    input logic [STREAM_QOS_W-1:0]  qos,
    input logic [STREAM_DATA_W-1:0] data
  );
    return {last, qos, data};
  endfunction

  function automatic stream_beat_t unpack_beat(input logic [STREAM_BEAT_W-1:0] beat);
    return stream_beat_t'(beat);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Beat storage for the packet FIFO: synchronous write, asynchronous read, no reset.
// The contents are meaningful only where the owner's pointers say so.
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = STREAM_BEAT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet buffer: the head is only released once a whole packet is stored,
// except when one oversize packet fills the FIFO, which switches to cut-through until its last beat.
module stream_packet_fifo
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = STREAM_DATA_W,
  parameter int T_QOS__WIDTH = STREAM_QOS_W,
  parameter int DEPTH        = 16,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [CW-1:0]           level_o,
  output logic [CW-1:0]           pkt_count_o,
  output logic                    forced_o
);

  localparam int            W         = T_DATA_WIDTH + T_QOS__WIDTH + 1;
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] level, pkt_count;
  logic          forced;
  logic          empty, full, wr, rd, wr_last, rd_last;
  logic [W-1:0]  wr_beat, rd_beat;

  // Extra pointer MSB separates full from empty when the address bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign s_ready_o = !full;
  assign m_valid_o = !empty && ((pkt_count != '0) || forced);
  assign wr        = s_valid_i && s_ready_o;
  assign rd        = m_valid_o && m_ready_i;
  assign wr_last   = wr && s_last_i;
  assign rd_last   = rd && m_last_o;

  assign wr_beat = {s_last_i, s_qos_i, s_data_i};
  assign {m_last_o, m_qos_o, m_data_o} = rd_beat;

  assign level_o     = level;
  assign pkt_count_o = pkt_count;
  assign forced_o    = forced;

  stream_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_beat),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr && !rd)      level <= level + CNT_ONE;
      else if (rd && !wr) level <= level - CNT_ONE;
      if (wr_last && !rd_last)      pkt_count <= pkt_count + CNT_ONE;
      else if (rd_last && !wr_last) pkt_count <= pkt_count - CNT_ONE;
    end
  end

  // A full FIFO with no complete packet can never release on its own, so cut through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          forced <= 1'b0;
    else if (rd_last)                    forced <= 1'b0;
    else if (full && pkt_count == '0)    forced <= 1'b1;
  end

  a_pkt_le_level: assert property (@(posedge clk) disable iff (!rst_n) pkt_count <= level);
  a_level_ptrs:   assert property (@(posedge clk) disable iff (!rst_n) level == CW'(wr_ptr - rd_ptr));
  a_level_ovf:    assert property (@(posedge clk) disable iff (!rst_n) !(wr && !rd && level == CNT_DEPTH));
  a_level_unf:    assert property (@(posedge clk) disable iff (!rst_n) !(rd && !wr && level == '0));
  a_pkt_ovf:      assert property (@(posedge clk) disable iff (!rst_n)
                                   !(wr_last && !rd_last && pkt_count == CNT_DEPTH));
  a_pkt_unf:      assert property (@(posedge clk) disable iff (!rst_n)
                                   !(rd_last && !wr_last && pkt_count == '0));

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Directed self-checking bench for stream_packet_fifo (DEPTH=16, 8-bit data, 4-bit qos).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_stream_packet_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data_i;
  logic [3:0] s_qos_i;
  logic       s_last_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic [3:0] m_qos_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [4:0] level_o;
  logic [4:0] pkt_count_o;
  logic       forced_o;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] bp_data [5] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
  logic [3:0] bp_qos  [5] = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h1};
  logic [7:0] rdy_pat     = 8'b1001_0110;

  stream_packet_fifo #(
    .T_DATA_WIDTH (8),
    .T_QOS__WIDTH (4),
    .DEPTH        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data_i    (s_data_i),
    .s_qos_i     (s_qos_i),
    .s_last_i    (s_last_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .m_data_o    (m_data_o),
    .m_qos_o     (m_qos_o),
    .m_last_o    (m_last_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .level_o     (level_o),
    .pkt_count_o (pkt_count_o),
    .forced_o    (forced_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] q,
                               input logic l, input logic r);
    s_valid_i = v;
    s_data_i  = d;
    s_qos_i   = q;
    s_last_i  = l;
    m_ready_i = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx;
    int guard;

    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 4'h0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_s_ready", s_ready_o, 1);
    checkOutput("rst_m_valid", m_valid_o, 0);
    checkOutput("rst_level", level_o, 0);
    checkOutput("rst_pkt", pkt_count_o, 0);
    checkOutput("rst_forced", forced_o, 0);

    $display("[TB] single 3-beat packet");
    applyStimulus(1, 8'h11, 4'h1, 0, 1);
    tick();
    checkOutput("sp_valid_b1", m_valid_o, 0);
    applyStimulus(1, 8'h22, 4'h2, 0, 1);
    tick();
    checkOutput("sp_valid_b2", m_valid_o, 0);
    checkOutput("sp_pkt_b2", pkt_count_o, 0);
    applyStimulus(1, 8'h33, 4'h3, 1, 1);
    tick();
    applyStimulus(0, 8'h00, 4'h0, 0, 1);
    checkOutput("sp_valid_b3", m_valid_o, 1);
    checkOutput("sp_pkt_b3", pkt_count_o, 1);
    checkOutput("sp_data0", m_data_o, 8'h11);
    tick();
    checkOutput("sp_data1", m_data_o, 8'h22);
    checkOutput("sp_valid1", m_valid_o, 1);
    tick();
    checkOutput("sp_data2", m_data_o, 8'h33);
    checkOutput("sp_last2", m_last_o, 1);
    tick();
    checkOutput("sp_valid_end", m_valid_o, 0);
    checkOutput("sp_pkt_end", pkt_count_o, 0);
    checkOutput("sp_level_end", level_o, 0);

    $display("[TB] fill with 16 single-beat packets");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'(i), 4'(i), 1, 0);
      tick();
    end
    applyStimulus(1, 8'hEE, 4'hE, 1, 1);
    checkOutput("fill_s_ready", s_ready_o, 0);
    checkOutput("fill_level", level_o, 16);
    checkOutput("fill_pkt", pkt_count_o, 16);
    checkOutput("fill_forced", forced_o, 0);
    tick();
    applyStimulus(0, 8'h00, 4'h0, 0, 1);
    checkOutput("full_rw_level", level_o, 15);
    checkOutput("full_rw_pkt", pkt_count_o, 15);
    checkOutput("full_rw_s_ready", s_ready_o, 1);
    for (int i = 1; i < 16; i++) begin
      checkOutput("fill_drain_valid", m_valid_o, 1);
      checkOutput("fill_drain_data", m_data_o, 32'(i));
      tick();
    end
    checkOutput("fill_drain_empty", m_valid_o, 0);
    checkOutput("fill_drain_level", level_o, 0);

    $display("[TB] oversize 20-beat packet");
    idx = 0;
    guard = 0;
    m_ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          applyStimulus(1, 8'(8'h80 + i), 4'(i), i == 19, 1);
          while (!s_ready_o && guard < 100) begin
            guard++;
            tick();
          end
          tick();
        end
        applyStimulus(0, 8'h00, 4'h0, 0, 1);
      end
      begin
        for (int cyc = 0; cyc < 120 && idx < 20; cyc++) begin
          if (m_valid_o) begin
            if (idx == 0) begin
              checkOutput("ovr_forced_on", forced_o, 1);
              checkOutput("ovr_first_level", level_o, 16);
              checkOutput("ovr_first_pkt", pkt_count_o, 0);
            end
            checkOutput("ovr_data", m_data_o, 32'(8'h80 + idx));
            checkOutput("ovr_last", m_last_o, (idx == 19) ? 1 : 0);
            idx++;
          end
          tick();
        end
      end
    join
    checkOutput("ovr_no_stall", (guard < 100) ? 1 : 0, 1);
    checkOutput("ovr_count", idx, 20);
    checkOutput("ovr_forced_off", forced_o, 0);
    checkOutput("ovr_level_end", level_o, 0);
    checkOutput("ovr_valid_end", m_valid_o, 0);

    $display("[TB] simultaneous last in and out");
    applyStimulus(1, 8'hA1, 4'h7, 1, 0);
    tick();
    applyStimulus(1, 8'hB0, 4'h8, 0, 0);
    tick();
    checkOutput("sim_pkt_pre", pkt_count_o, 1);
    applyStimulus(1, 8'hB1, 4'h9, 1, 1);
    checkOutput("sim_head_a", m_data_o, 8'hA1);
    tick();
    applyStimulus(0, 8'h00, 4'h0, 0, 1);
    checkOutput("sim_pkt_same", pkt_count_o, 1);
    checkOutput("sim_level", level_o, 2);
    checkOutput("sim_valid_b0", m_valid_o, 1);
    checkOutput("sim_data_b0", m_data_o, 8'hB0);
    tick();
    checkOutput("sim_valid_b1", m_valid_o, 1);
    checkOutput("sim_data_b1", m_data_o, 8'hB1);
    tick();
    checkOutput("sim_valid_end", m_valid_o, 0);
    checkOutput("sim_pkt_end", pkt_count_o, 0);

    $display("[TB] backpressure on a 5-beat packet");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, bp_data[i], bp_qos[i], i == 4, 0);
      tick();
    end
    applyStimulus(0, 8'h00, 4'h0, 0, 0);
    checkOutput("bp_level", level_o, 5);
    checkOutput("bp_pkt", pkt_count_o, 1);
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      m_ready_i = rdy_pat[cyc % 8];
      if (m_valid_o) begin
        checkOutput("bp_data", m_data_o, bp_data[idx]);
        checkOutput("bp_qos", m_qos_o, bp_qos[idx]);
        checkOutput("bp_last", m_last_o, (idx == 4) ? 1 : 0);
        if (m_ready_i) idx++;
      end else begin
        checkOutput("bp_gap", m_valid_o, 1);
      end
      tick();
    end
    m_ready_i = 1'b0;
    checkOutput("bp_count", idx, 5);
    checkOutput("bp_level_end", level_o, 0);

    $display("[TB] reset mid-packet");
    applyStimulus(1, 8'hC0, 4'h1, 0, 1);
    tick();
    applyStimulus(1, 8'hC1, 4'h2, 0, 1);
    tick();
    applyStimulus(0, 8'h00, 4'h0, 0, 1);
    checkOutput("mr_level_pre", level_o, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_level", level_o, 0);
    checkOutput("mr_valid", m_valid_o, 0);
    checkOutput("mr_s_ready", s_ready_o, 1);
    checkOutput("mr_pkt", pkt_count_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1, 8'h77, 4'h2, 1, 1);
    tick();
    applyStimulus(0, 8'h00, 4'h0, 0, 1);
    checkOutput("mr_new_valid", m_valid_o, 1);
    checkOutput("mr_new_data", m_data_o, 8'h77);
    checkOutput("mr_new_qos", m_qos_o, 4'h2);
    checkOutput("mr_new_level", level_o, 1);
    tick();
    checkOutput("mr_new_done", m_valid_o, 0);
    checkOutput("mr_new_level_end", level_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_packet_fifo.md
Name: stream_packet_fifo

Overview:
- Per-input store-and-forward packet buffer. One instance sits directly upstream of each stream_arbiter input port.
- It presents valid only when at least one complete packet (through the last beat) is stored. This guarantees that a granted stream never has valid gaps mid-packet, so arbiter grant release on last stays clean.
- It buffers data, qos and last per beat, and exports occupancy/packet status for monitoring.

Parameters:
- T_DATA_WIDTH, 8, beat data width
- T_QOS__WIDTH, 4, qos field width, stored per beat
- DEPTH, 16, number of beat entries; power of two, >= 2
- localparam AW = $clog2(DEPTH), address width
- localparam CW = $clog2(DEPTH+1), count width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data_i  in  T_DATA_WIDTH  input beat data
- s_qos_i  in  T_QOS__WIDTH  input beat qos
- s_last_i  in  1  input beat is last of packet
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  FIFO can accept a beat
- m_data_o  out  T_DATA_WIDTH  head beat data
- m_qos_o  out  T_QOS__WIDTH  head beat qos
- m_last_o  out  1  head beat last flag
- m_valid_o  out  1  head beat releasable
- m_ready_i  in  1  downstream accepts
- level_o  out  CW  beats stored
- pkt_count_o  out  CW  complete packets stored
- forced_o  out  1  oversize cut-through mode active

Behaviour:
- Storage: DEPTH x {last, qos, data}. Write and read pointers are AW+1 bits wide; the MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- Memory contents are not reset. Read is asynchronous from the rd_ptr entry, so m_data_o, m_qos_o and m_last_o reflect the head entry combinationally.
- wr = s_valid_i & s_ready_o. rd = m_valid_o & m_ready_i.
- s_ready_o = !full. There is no write-through when full, even if a read occurs in the same cycle; s_ready_o must not depend on m_ready_i.
- level: +1 on wr only, -1 on rd only, unchanged on both. level_o = level.
- pkt_count: +1 on wr with s_last_i=1, -1 on rd with m_last_o=1, unchanged when both occur.
- pkt_count never exceeds level. Neither counter may underflow or overflow; an assertion is required.
- forced state (registered flag):
  - Set when full & pkt_count==0 at a clock edge. This covers a packet longer than DEPTH, which would otherwise deadlock.
  - Cleared on rd of a beat with m_last_o=1.
  - Set has priority only if that rd does not occur in the same cycle.
- m_valid_o = !empty & (pkt_count!=0 | forced).
- Latency:
  - Last beat written at edge N -> pkt_count=1 and m_valid_o=1 in the cycle after edge N.
  - Minimum in-to-out for a 1-beat packet is 1 cycle.
  - Non-last beats alone never raise m_valid_o, unless forced.
- Handshake:
  - Once m_valid_o=1 it stays 1, with stable data/qos/last, until rd. Release is packet-granular, so a released packet drains without gaps.
  - In forced mode, gaps are possible when the FIFO is empty mid-packet. This is documented as the only permitted gap case.
- Ordering: strict FIFO; beats and packets are never reordered or dropped.
- Reset values:
  - s_ready_o=1, m_valid_o=0, level_o=0, pkt_count_o=0, forced_o=0.
  - m_data_o, m_qos_o and m_last_o are don't-care while m_valid_o=0.
- Reset mid-operation: all pointers, counters and forced are cleared asynchronously. Stored beats are discarded, and partial packets are lost.
- Back-to-back: sustained 1 beat/cycle in and out once a packet is complete; full-depth utilisation.

Decomposition:
- Package stream_pkg holds:
  - default width constants STREAM_DATA_W=8 and STREAM_QOS_W=4;
  - a function packing {last, qos, data} to a beat vector, and the matching unpack;
  - shared with stream_arbiter instantiation code.
- One sub-module, stream_fifo_mem: DEPTH x W register array with a synchronous write port and an asynchronous read port, no reset.
- The pointer, counter and forced logic stays in stream_packet_fifo.

Test Plan:
- Single packet: write 3 beats (data 0x11, 0x22, 0x33; last on 3rd) with m_ready_i=1 -> m_valid_o stays 0 until the cycle after 0x33 is written, then 0x11, 0x22, 0x33 emerge on consecutive cycles; pkt_count_o goes 0->1->0.
- Fill: DEPTH=16, write 16 single-beat packets with m_ready_i=0 -> s_ready_o=0 after 16th; level_o=16, pkt_count_o=16. Then a simultaneous write attempt plus read -> no write accepted that cycle, level_o=15.
- Oversize: DEPTH=16, 20-beat packet with m_ready_i=1 -> at full with pkt_count_o=0, forced_o=1 next cycle and beats 0..19 emerge in order; forced_o=0 after beat 19 (last) is read.
- Simultaneous last: write last of packet B in the same cycle as reading last of packet A -> pkt_count_o unchanged (1), B then released without gap.
- Backpressure stability: toggle m_ready_i randomly during a 5-beat packet -> data/qos/last stable while valid & !ready; output sequence matches input exactly, qos per beat preserved (e.g. 0x3, 0xA).
- Reset mid-packet: assert rst_n low after 2 of 4 beats -> immediately level_o=0, m_valid_o=0, s_ready_o=1. A new 1-beat packet after release is output alone.
